id_stage_pipelined: RTL and testbench

Parametrised decode stage for the ARM 5-stage core. It merges instruction decode, condition check, register file and the ID/EXE pipeline register into one block, and adds a valid/ready handshake, stall, flush and write-back bypass. It sits between the IF/ID register and the EXE stage. The hazard unit consumes the combinational src1/src2/two_src/rn_valid outputs.

---
 rtl/arm_pkg.sv | 64 ++++++
 rtl/condition_check.sv | 38 +++
 rtl/register_file_param.sv | 60 ++++++
 rtl/id_stage_pipelined.sv | 192 +++++++++++++++++++
 tb/tb_id_stage_pipelined.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared decode constants and control bundle for the ARM 5-stage core.
// Latency: none (types, constants only).
// Backpressure: not applicable.
package arm_pkg;

    // ALU commands driven to EXE
    localparam logic [3:0] EXE_NOP = 4'b0000;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_MVN = 4'b1001;

    // Data-processing opcodes, instruction[24:21]
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    // Instruction classes, instruction[27:26]
    localparam logic [1:0] MODE_DP  = 2'b00;
    localparam logic [1:0] MODE_MEM = 2'b01;
    localparam logic [1:0] MODE_BR  = 2'b10;

    // Condition codes, instruction[31:28]
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/condition_check.sv
// ARM condition evaluation against status flags.
// Latency: combinational.
// Backpressure: none.
// Ports: cond (instruction[31:28]), sr {N,Z,C,V}, pass (1 = execute).
module condition_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] sr,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = sr;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;  // NV: never
        endcase
    end

endmodule

// File: rtl/register_file_param.sv
// General-purpose register file, one write port, two combinational read ports.
// Latency: write lands on the clock edge; reads combinational (optional same-cycle bypass).
// Backpressure: none.
// Ports: clk, rst (sync active-low), wr_en/wr_idx/wr_data, rd_idx1/rd_data1, rd_idx2/rd_data2.
module register_file_param #(
    parameter int unsigned NUM_REGS = 15,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 4,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [REG_AW-1:0] rd_idx1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [REG_AW-1:0] rd_idx2,
    output logic [DATA_W-1:0] rd_data2
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Indices past the last entry (e.g. R15, the PC) are not backed by storage.
    logic wr_ok, rd1_ok, rd2_ok;
    assign wr_ok  = 32'(wr_idx)  < NUM_REGS;
    assign rd1_ok = 32'(rd_idx1) < NUM_REGS;
    assign rd2_ok = 32'(rd_idx2) < NUM_REGS;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && wr_ok) begin
            regs[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        rd_data1 = '0;
        if (rd1_ok) begin
            rd_data1 = regs[rd_idx1];
            if (BYPASS && wr_en && (wr_idx == rd_idx1)) begin
                rd_data1 = wr_data;
            end
        end
    end

    always_comb begin
        rd_data2 = '0;
        if (rd2_ok) begin
            rd_data2 = regs[rd_idx2];
            if (BYPASS && wr_en && (wr_idx == rd_idx2)) begin
                rd_data2 = wr_data;
            end
        end
    end

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: decode + condition check + register read, ending in the ID/EXE register.
// Latency: 1 cycle from acceptance (in_valid & in_ready) to out_valid.
// Backpressure: holds ID/EXE while out_valid & !out_ready; in_ready drops on stall or hazard.
// Ports: in_valid/in_ready/instruction/pc_in/sr from IF/ID; hazard, flush; wb_* write-back;
//        src1/src2/two_src/rn_valid to the hazard unit; registered control/operands to EXE.
module id_stage_pipelined #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 15,
    parameter int unsigned REG_AW    = 4,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic [31:0]       pc_in,
    input  logic [3:0]        sr,
    input  logic              hazard,
    input  logic              flush,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic              two_src,
    output logic              rn_valid,
    output logic              wb_en_o,
    output logic              mem_r_en,
    output logic              mem_w_en,
    output logic              b,
    output logic              s_o,
    output logic [3:0]        exe_cmd,
    output logic [DATA_W-1:0] val_rn,
    output logic [DATA_W-1:0] val_rm,
    output logic              imm,
    output logic [11:0]       shift_operand,
    output logic [23:0]       signed_imm_24,
    output logic [REG_AW-1:0] dest,
    output logic [31:0]       pc_out
);

    import arm_pkg::*;

    logic [3:0] cond;
    logic [1:0] mode;
    logic       imm_bit;
    logic [3:0] opcode;
    logic       s_bit;

    assign cond    = instruction[31:28];
    assign mode    = instruction[27:26];
    assign imm_bit = instruction[25];
    assign opcode  = instruction[24:21];
    assign s_bit   = instruction[20];

    logic [REG_AW-1:0] rn_idx, rd_idx, rm_idx;
    assign rn_idx = instruction[16 +: REG_AW];
    assign rd_idx = instruction[12 +: REG_AW];
    assign rm_idx = instruction[0  +: REG_AW];

    // STR reads Rd as the store data, so it takes the second read port.
    logic is_str;
    assign is_str   = (mode == MODE_MEM) && !s_bit;
    assign src1     = rn_idx;
    assign src2     = is_str ? rd_idx : rm_idx;
    assign two_src  = !imm_bit || is_str;
    assign rn_valid = !((mode == MODE_BR) ||
                        ((mode == MODE_DP) && ((opcode == OP_MOV) || (opcode == OP_MVN))));

    ctrl_t dec_ctrl;

    always_comb begin
        dec_ctrl = CTRL_NONE;
        case (mode)
            MODE_DP: begin
                dec_ctrl.wb_en = 1'b1;
                dec_ctrl.s     = s_bit;
                case (opcode)
                    OP_MOV: dec_ctrl.exe_cmd = EXE_MOV;
                    OP_MVN: dec_ctrl.exe_cmd = EXE_MVN;
                    OP_ADD: dec_ctrl.exe_cmd = EXE_ADD;
                    OP_ADC: dec_ctrl.exe_cmd = EXE_ADC;
                    OP_SUB: dec_ctrl.exe_cmd = EXE_SUB;
                    OP_SBC: dec_ctrl.exe_cmd = EXE_SBC;
                    OP_AND: dec_ctrl.exe_cmd = EXE_AND;
                    OP_ORR: dec_ctrl.exe_cmd = EXE_ORR;
                    OP_EOR: dec_ctrl.exe_cmd = EXE_EOR;
                    // Compare/test only update flags.
                    OP_CMP: begin
                        dec_ctrl.exe_cmd = EXE_SUB;
                        dec_ctrl.wb_en   = 1'b0;
                        dec_ctrl.s       = 1'b1;
                    end
                    OP_TST: begin
                        dec_ctrl.exe_cmd = EXE_AND;
                        dec_ctrl.wb_en   = 1'b0;
                        dec_ctrl.s       = 1'b1;
                    end
                    default: dec_ctrl = CTRL_NONE;
                endcase
            end
            MODE_MEM: begin
                // S doubles as the load/store select; address is always base + offset.
                dec_ctrl.exe_cmd  = EXE_ADD;
                dec_ctrl.wb_en    = s_bit;
                dec_ctrl.mem_r_en = s_bit;
                dec_ctrl.mem_w_en = !s_bit;
            end
            MODE_BR: begin
                dec_ctrl.b = 1'b1;
            end
            default: dec_ctrl = CTRL_NONE;
        endcase
    end

    logic cond_pass;

    condition_check u_cond (
        .cond (cond),
        .sr   (sr),
        .pass (cond_pass)
    );

    logic [DATA_W-1:0] rd_rn, rd_rm;

    register_file_param #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .REG_AW   (REG_AW),
        .BYPASS   (BYPASS_WB)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wb_en),
        .wr_idx   (wb_dest),
        .wr_data  (wb_result),
        .rd_idx1  (src1),
        .rd_data1 (rd_rn),
        .rd_idx2  (src2),
        .rd_data2 (rd_rm)
    );

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall && !hazard;

    ctrl_t ctrl_q;
    assign wb_en_o  = ctrl_q.wb_en;
    assign mem_r_en = ctrl_q.mem_r_en;
    assign mem_w_en = ctrl_q.mem_w_en;
    assign b        = ctrl_q.b;
    assign s_o      = ctrl_q.s;
    assign exe_cmd  = ctrl_q.exe_cmd;

    // Flush overrides the stall hold; bubbles clear control but leave operand fields as they were.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            ctrl_q        <= CTRL_NONE;
            val_rn        <= '0;
            val_rm        <= '0;
            imm           <= 1'b0;
            shift_operand <= '0;
            signed_imm_24 <= '0;
            dest          <= '0;
            pc_out        <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            ctrl_q    <= CTRL_NONE;
        end else if (!stall) begin
            if (hazard || !in_valid) begin
                out_valid <= 1'b0;
                ctrl_q    <= CTRL_NONE;
            end else begin
                out_valid     <= 1'b1;
                // A failed condition still advances, annulled.
                ctrl_q        <= cond_pass ? dec_ctrl : CTRL_NONE;
                val_rn        <= rd_rn;
                val_rm        <= rd_rm;
                imm           <= imm_bit;
                shift_operand <= instruction[11:0];
                signed_imm_24 <= instruction[23:0];
                dest          <= rd_idx;
                pc_out        <= pc_in;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed cases followed by randomized traffic
// compared against a behavioural model. A second instance without write-back bypass shares inputs.
module tb_id_stage_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, hazard, flush, wb_en, out_ready;
    logic [31:0] instruction, pc_in, wb_result;
    logic [3:0]  sr, wb_dest;

    logic        in_ready, out_valid, two_src, rn_valid, wb_en_o, mem_r_en, mem_w_en, b, s_o, imm;
    logic [3:0]  src1, src2, exe_cmd, dest;
    logic [31:0] val_rn, val_rm, pc_out;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    logic        b_in_ready, b_out_valid, b_two_src, b_rn_valid, b_wb_en_o, b_mem_r_en, b_mem_w_en;
    logic        b_b, b_s_o, b_imm;
    logic [3:0]  b_src1, b_src2, b_exe_cmd, b_dest;
    logic [31:0] b_val_rn, b_val_rm, b_pc_out;
    logic [11:0] b_shift_operand;
    logic [23:0] b_signed_imm_24;

    id_stage_pipelined #(.BYPASS_WB(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc_in(pc_in), .sr(sr), .hazard(hazard), .flush(flush),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result), .out_ready(out_ready),
        .out_valid(out_valid), .src1(src1), .src2(src2), .two_src(two_src), .rn_valid(rn_valid),
        .wb_en_o(wb_en_o), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s_o(s_o),
        .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24), .dest(dest), .pc_out(pc_out)
    );

    id_stage_pipelined #(.BYPASS_WB(1'b0)) dut_nobyp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .instruction(instruction), .pc_in(pc_in), .sr(sr), .hazard(hazard), .flush(flush),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_result(wb_result), .out_ready(out_ready),
        .out_valid(b_out_valid), .src1(b_src1), .src2(b_src2), .two_src(b_two_src),
        .rn_valid(b_rn_valid), .wb_en_o(b_wb_en_o), .mem_r_en(b_mem_r_en), .mem_w_en(b_mem_w_en),
        .b(b_b), .s_o(b_s_o), .exe_cmd(b_exe_cmd), .val_rn(b_val_rn), .val_rm(b_val_rm),
        .imm(b_imm), .shift_operand(b_shift_operand), .signed_imm_24(b_signed_imm_24),
        .dest(b_dest), .pc_out(b_pc_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit       wb;
        bit       mr;
        bit       mw;
        bit       br;
        bit       s;
        bit [3:0] cmd;
    } ectl_t;

    int unsigned dp_cmd [bit [3:0]];   // data-processing opcode -> ALU command
    bit [31:0]   regs [15];

    bit          m_valid, m_imm, m_data_chk;
    ectl_t       m_c;
    bit [31:0]   m_rn, m_rm, m_rn0, m_rm0, m_pc;
    bit [11:0]   m_shop;
    bit [23:0]   m_simm;
    bit [3:0]    m_dest;

    function automatic ectl_t no_ctl();
        ectl_t c;
        c.wb = 0; c.mr = 0; c.mw = 0; c.br = 0; c.s = 0; c.cmd = 4'd0;
        return c;
    endfunction

    function automatic ectl_t ref_ctrl(input bit [31:0] ins);
        ectl_t     c   = no_ctl();
        bit [3:0]  opc = ins[24:21];
        bit [1:0]  md  = ins[27:26];
        if (md == 2'b00 && dp_cmd.exists(opc)) begin
            c.cmd = 4'(dp_cmd[opc]);
            if (opc == 4'b1010 || opc == 4'b1000) begin   // CMP, TST
                c.wb = 0; c.s = 1;
            end else begin
                c.wb = 1; c.s = ins[20];
            end
        end else if (md == 2'b01) begin
            c.cmd = 4'b0010;
            if (ins[20]) begin c.wb = 1; c.mr = 1; end    // LDR
            else         begin c.mw = 1; end              // STR
        end else if (md == 2'b10) begin
            c.br = 1;
        end
        return c;
    endfunction

    function automatic bit ref_cond(input bit [3:0] cnd, input bit [3:0] f);
        bit n = f[3], z = f[2], c = f[1], v = f[0];
        case (cnd)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [31:0] rdreg(input bit [3:0] idx, input bit byp);
        if (idx >= 4'd15) return 32'd0;
        if (byp && wb_en && wb_dest == idx) return wb_result;
        return regs[idx];
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle(input bit comb_chk);
        bit       stall_e, str, pass;
        bit [3:0] rn_i, rd_i, rm_i, s2;
        ectl_t    c;
        #1;
        rn_i    = instruction[19:16];
        rd_i    = instruction[15:12];
        rm_i    = instruction[3:0];
        str     = (instruction[27:26] == 2'b01) && !instruction[20];
        s2      = str ? rd_i : rm_i;
        stall_e = m_valid && !out_ready;
        if (comb_chk) begin
            chk("in_ready", 32'(in_ready), 32'(!stall_e && !hazard));
            chk("src1", 32'(src1), 32'(rn_i));
            chk("src2", 32'(src2), 32'(s2));
            chk("two_src", 32'(two_src), 32'(!instruction[25] || str));
            chk("rn_valid", 32'(rn_valid), 32'(!(instruction[27:26] == 2'b10 ||
                (instruction[27:26] == 2'b00 &&
                 (instruction[24:21] == 4'b1101 || instruction[24:21] == 4'b1111)))));
        end
        if (!rst) begin
            m_valid = 0; m_c = no_ctl(); m_rn = 0; m_rm = 0; m_rn0 = 0; m_rm0 = 0;
            m_imm = 0; m_shop = 0; m_simm = 0; m_dest = 0; m_pc = 0; m_data_chk = 1;
            for (int i = 0; i < 15; i++) regs[i] = 32'd0;
        end else begin
            if (flush) begin
                m_valid = 0; m_c = no_ctl();
            end else if (!stall_e) begin
                if (hazard || !in_valid) begin
                    m_valid = 0; m_c = no_ctl();
                end else begin
                    pass    = ref_cond(instruction[31:28], sr);
                    c       = ref_ctrl(instruction);
                    m_valid = 1;
                    m_c     = pass ? c : no_ctl();
                    m_rn    = rdreg(rn_i, 1'b1);
                    m_rm    = rdreg(s2, 1'b1);
                    m_rn0   = rdreg(rn_i, 1'b0);
                    m_rm0   = rdreg(s2, 1'b0);
                    m_imm   = instruction[25];
                    m_shop  = instruction[11:0];
                    m_simm  = instruction[23:0];
                    m_dest  = rd_i;
                    m_pc    = pc_in;
                end
            end
            m_data_chk = m_valid;
            if (wb_en && wb_dest < 4'd15) regs[wb_dest] = wb_result;
        end
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("nobyp_out_valid", 32'(b_out_valid), 32'(m_valid));
        chk("wb_en_o", 32'(wb_en_o), 32'(m_c.wb));
        chk("mem_r_en", 32'(mem_r_en), 32'(m_c.mr));
        chk("mem_w_en", 32'(mem_w_en), 32'(m_c.mw));
        chk("b", 32'(b), 32'(m_c.br));
        chk("s_o", 32'(s_o), 32'(m_c.s));
        chk("exe_cmd", 32'(exe_cmd), 32'(m_c.cmd));
        if (m_data_chk) begin
            chk("val_rn", val_rn, m_rn);
            chk("val_rm", val_rm, m_rm);
            chk("nobyp_val_rn", b_val_rn, m_rn0);
            chk("nobyp_val_rm", b_val_rm, m_rm0);
            chk("imm", 32'(imm), 32'(m_imm));
            chk("shift_operand", 32'(shift_operand), 32'(m_shop));
            chk("signed_imm_24", 32'(signed_imm_24), 32'(m_simm));
            chk("dest", 32'(dest), 32'(m_dest));
            chk("pc_out", pc_out, m_pc);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1; in_valid = 0; hazard = 0; flush = 0; wb_en = 0; out_ready = 1;
    endtask

    initial begin
        dp_cmd[4'b1101] = 1;  dp_cmd[4'b1111] = 9;  dp_cmd[4'b0100] = 2;  dp_cmd[4'b0101] = 3;
        dp_cmd[4'b0010] = 4;  dp_cmd[4'b0110] = 5;  dp_cmd[4'b0000] = 6;  dp_cmd[4'b1100] = 7;
        dp_cmd[4'b0001] = 8;  dp_cmd[4'b1010] = 4;  dp_cmd[4'b1000] = 6;
        m_valid = 0; m_c = no_ctl(); m_data_chk = 0;

        idle();
        rst = 0; instruction = 32'h0; pc_in = 32'h0; sr = 4'h0; wb_dest = 4'd0; wb_result = 32'h0;
        @(negedge clk);
        cycle(0);
        cycle(1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_val_rn", val_rn, 32'd0);
        rst = 1;

        // preload R2 = 5, R3 = 7
        wb_en = 1; wb_dest = 4'd2; wb_result = 32'd5; cycle(1);
        wb_dest = 4'd3; wb_result = 32'd7; cycle(1);
        wb_en = 0;

        // ADD R1,R2,R3
        in_valid = 1; instruction = 32'hE0821003; pc_in = 32'h104; cycle(1);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_cmd", 32'(exe_cmd), 32'b0010);
        chk("add_wb", 32'(wb_en_o), 32'd1);
        chk("add_rn", val_rn, 32'd5);
        chk("add_rm", val_rm, 32'd7);
        chk("add_dest", 32'(dest), 32'd1);

        // same-cycle write-back of R2
        wb_en = 1; wb_dest = 4'd2; wb_result = 32'd9; cycle(1); wb_en = 0;
        chk("bypass_rn", val_rn, 32'd9);
        chk("nobypass_rn", b_val_rn, 32'd5);

        // ADDEQ, Z clear then set
        instruction = 32'h00821003; sr = 4'b0000; cycle(1);
        chk("addeq_fail_valid", 32'(out_valid), 32'd1);
        chk("addeq_fail_wb", 32'(wb_en_o), 32'd0);
        chk("addeq_fail_cmd", 32'(exe_cmd), 32'd0);
        sr = 4'b0100; cycle(1);
        chk("addeq_pass_wb", 32'(wb_en_o), 32'd1);

        // stall for 3 cycles with SUB R6,R2,R3 waiting
        out_ready = 0; instruction = 32'hE0426003; sr = 4'b0000; pc_in = 32'h200;
        repeat (3) begin
            #1; chk("stall_in_ready", 32'(in_ready), 32'd0);
            cycle(1);
            chk("stall_hold_cmd", 32'(exe_cmd), 32'b0010);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1; cycle(1);
        chk("after_stall_cmd", 32'(exe_cmd), 32'b0100);
        chk("after_stall_dest", 32'(dest), 32'd6);

        // hazard
        hazard = 1; #1; chk("hazard_in_ready", 32'(in_ready), 32'd0);
        cycle(1); chk("hazard_bubble", 32'(out_valid), 32'd0);
        hazard = 0;

        // flush during stall
        instruction = 32'hE0821003; cycle(1);
        out_ready = 0; flush = 1; cycle(1);
        chk("flush_in_stall", 32'(out_valid), 32'd0);
        flush = 0; out_ready = 1;

        // STR R4,[R5]
        instruction = 32'hE5854000;
        #1;
        chk("str_src1", 32'(src1), 32'd5);
        chk("str_src2", 32'(src2), 32'd4);
        chk("str_two_src", 32'(two_src), 32'd1);
        cycle(1);
        chk("str_mem_w", 32'(mem_w_en), 32'd1);
        chk("str_wb", 32'(wb_en_o), 32'd0);

        // reset while stalled
        instruction = 32'hE0821003; cycle(1);
        out_ready = 0; rst = 0; cycle(1);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_cmd", 32'(exe_cmd), 32'd0);
        chk("rst_mid_pc", pc_out, 32'd0);
        rst = 1; out_ready = 1;

        // randomized traffic
        repeat (800) begin
            instruction = $urandom;
            if ($urandom_range(3) != 0) instruction[31:28] = 4'hE;
            pc_in     = $urandom;
            sr        = 4'($urandom_range(15));
            in_valid  = ($urandom_range(9) < 8);
            out_ready = ($urandom_range(3) != 0);
            hazard    = ($urandom_range(9) == 0);
            flush     = ($urandom_range(19) == 0);
            wb_en     = $urandom_range(1) == 1;
            wb_dest   = 4'($urandom_range(15));
            wb_result = $urandom;
            rst       = ($urandom_range(99) != 0);
            cycle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
